// File: rtl/sd_read_sched_if.sv
// sd_read_sched_if
//   Bundles every non-clock, non-reset signal of the SD read scheduler.
//   slave  : the scheduler itself (requests and SD handshakes in, grants and
//            SD controls out).
//   master : the surrounding logic (requesters plus SD SPI controller).
//   Signals:
//     req[1:0], addr0, addr1    requester side: level requests and block addresses
//     gnt, done, err [1:0]      requester side: one-hot grant, completion, timeout
//     sd_init / init_ok         controller initialisation handshake
//     sd_ren / sd_addr /
//     sd_rd_done                block read handshake
//     sd_release                returns the controller to idle (its fifo_busy)
//     init_fail, busy           status
interface sd_read_sched_if #(
    parameter int ADDR_W = 32
);
    logic [1:0]        req;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [1:0]        err;
    logic              sd_init;
    logic              init_ok;
    logic              sd_ren;
    logic [ADDR_W-1:0] sd_addr;
    logic              sd_rd_done;
    logic              sd_release;
    logic              init_fail;
    logic              busy;

    modport master (
        output req, addr0, addr1, init_ok, sd_rd_done,
        input  gnt, done, err, sd_init, sd_ren, sd_addr, sd_release, init_fail, busy
    );

    modport slave (
        input  req, addr0, addr1, init_ok, sd_rd_done,
        output gnt, done, err, sd_init, sd_ren, sd_addr, sd_release, init_fail, busy
    );
endinterface

// File: rtl/sd_read_sched.sv
// sd_read_sched
//   Sequences an SD card SPI controller: runs card initialisation once after
//   reset, then arbitrates CMD17 block reads between two requesters
//   (port 0 = UART command path, port 1 = prefetch engine), one read at a
//   time. Every initialisation and read is supervised by a timeout; after
//   each one, sd_release is held for REL_CYC cycles to return the controller
//   to idle.
//   Ports:
//     clk  system clock
//     rst  asynchronous, active-high reset
//     bus  sd_read_sched_if.slave (requester and SD controller handshakes)
//   All SD-side inputs are already synchronous to clk.
module sd_read_sched #(
    parameter logic [23:0] INIT_TIMEOUT = 24'd5_000_000,
    parameter logic [23:0] RD_TIMEOUT   = 24'd1_000_000,
    parameter logic [3:0]  REL_CYC      = 4'd8,
    parameter int          ADDR_W       = 32
) (
    input  logic           clk,
    input  logic           rst,
    sd_read_sched_if.slave bus
);

    typedef enum logic [2:0] {
        S_INIT,
        S_INIT_WAIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RELEASE,
        S_FAIL
    } state_t;

    state_t            state;
    logic [23:0]       tmr;
    logic              cur;      // index of the requester being served
    logic              rr_last;  // index granted most recently
    logic [ADDR_W-1:0] addr_q;

    logic [1:0]        gnt_q;
    logic [1:0]        done_q;
    logic [1:0]        err_q;
    logic              sd_init_q;
    logic              sd_ren_q;
    logic              sd_release_q;
    logic              init_fail_q;
    logic              busy_q;

    logic [23:0]       tmr_dec;
    logic              pick;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Timer steps down by one per cycle and sticks at zero.
    assign tmr_dec = (tmr == 24'd0) ? 24'd0 : tmr - 24'd1;

    // Winner selection: a lone requester wins outright; with both requesting,
    // the one not served last time wins.
    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it holding a stale value (a latch).
    always_comb begin
        pick = 1'b0;
        case (bus.req)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~rr_last;
            default: pick = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below reads the pre-edge value of each register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_INIT;
            tmr          <= 24'd0;
            cur          <= 1'b0;
            rr_last      <= 1'b1;
            addr_q       <= '0;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            sd_init_q    <= 1'b0;
            sd_ren_q     <= 1'b0;
            sd_release_q <= 1'b0;
            init_fail_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // done and err are single-cycle pulses.
            done_q <= 2'b00;
            err_q  <= 2'b00;

            case (state)
                S_INIT: begin
                    sd_init_q <= 1'b1;
                    busy_q    <= 1'b1;
                    tmr       <= INIT_TIMEOUT;
                    state     <= S_INIT_WAIT;
                end

                S_INIT_WAIT: begin
                    tmr <= tmr_dec;
                    // Success is tested first so it wins over a simultaneous expiry.
                    if (bus.init_ok) begin
                        sd_init_q    <= 1'b0;
                        sd_release_q <= 1'b1;
                        tmr          <= 24'(REL_CYC);
                        state        <= S_RELEASE;
                    end else if (tmr == 24'd0) begin
                        sd_init_q   <= 1'b0;
                        init_fail_q <= 1'b1;
                        state       <= S_FAIL;
                    end
                end

                S_IDLE: begin
                    if (bus.req != 2'b00) begin
                        cur     <= pick;
                        rr_last <= pick;
                        addr_q  <= pick ? bus.addr1 : bus.addr0;
                        gnt_q   <= onehot(pick);
                        busy_q  <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    sd_ren_q <= 1'b1;
                    tmr      <= RD_TIMEOUT;
                    state    <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    tmr <= tmr_dec;
                    if (bus.sd_rd_done || tmr == 24'd0) begin
                        sd_ren_q     <= 1'b0;
                        sd_release_q <= 1'b1;
                        tmr          <= 24'(REL_CYC);
                        state        <= S_RELEASE;
                        // Completion wins over a simultaneous expiry.
                        if (bus.sd_rd_done) done_q <= onehot(cur);
                        else                err_q  <= onehot(cur);
                    end
                end

                S_RELEASE: begin
                    // Entered with tmr = REL_CYC; leaving when it reaches 1
                    // keeps sd_release high for exactly REL_CYC cycles.
                    if (tmr <= 24'd1) begin
                        sd_release_q <= 1'b0;
                        gnt_q        <= 2'b00;
                        busy_q       <= 1'b0;
                        tmr          <= 24'd0;
                        state        <= S_IDLE;
                    end else begin
                        tmr <= tmr_dec;
                    end
                end

                S_FAIL: begin
                    // Terminal: only reset leaves this state.
                    sd_init_q   <= 1'b0;
                    init_fail_q <= 1'b1;
                    busy_q      <= 1'b1;
                end

                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.sd_init    = sd_init_q;
    assign bus.sd_ren     = sd_ren_q;
    assign bus.sd_addr    = addr_q;
    assign bus.sd_release = sd_release_q;
    assign bus.init_fail  = init_fail_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sd_read_sched.sv
// tb_sd_read_sched
//   Self-checking bench for sd_read_sched. Two instances share the clock:
//   dut (INIT_TIMEOUT=1000, RD_TIMEOUT=20) for normal operation and dut_f
//   (INIT_TIMEOUT=50) whose init_ok never rises. Expected grants and
//   addresses come from a small round-robin model and are queued when
//   requests are driven, then popped when the read is serviced.
module tb_sd_read_sched;

    localparam int ADDR_W = 32;

    logic clk;
    logic rst;
    logic rst_f;

    sd_read_sched_if #(.ADDR_W(ADDR_W)) bus ();
    sd_read_sched_if #(.ADDR_W(ADDR_W)) bus_f ();

    sd_read_sched #(
        .INIT_TIMEOUT(24'd1000),
        .RD_TIMEOUT  (24'd20),
        .REL_CYC     (4'd8),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    sd_read_sched #(
        .INIT_TIMEOUT(24'd50),
        .RD_TIMEOUT  (24'd20),
        .REL_CYC     (4'd8),
        .ADDR_W      (ADDR_W)
    ) dut_f (
        .clk(clk),
        .rst(rst_f),
        .bus(bus_f.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        gnt;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic rr_m;  // model of the last granted index

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of the arbiter: returns the winning index and updates rr_m.
    function automatic logic model_pick(input logic [1:0] r);
        logic w;
        if (r == 2'b11) w = ~rr_m;
        else            w = (r == 2'b10);
        rr_m = w;
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        rst_f = 1'b1;
        tick();
        tick();
        compared++;
        if ({bus.gnt, bus.done, bus.err, bus.sd_init, bus.sd_ren, bus.sd_release,
             bus.init_fail, bus.busy} !== 11'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got gnt=%b done=%b err=%b init=%b ren=%b rel=%b fail=%b busy=%b, want all 0",
                     bus.gnt, bus.done, bus.err, bus.sd_init, bus.sd_ren, bus.sd_release,
                     bus.init_fail, bus.busy);
        end
        rr_m = 1'b1;
        rst = 1'b0;
    endtask

    task automatic test_init();
        int rel_cnt;
        tick();  // INIT -> INIT_WAIT, sd_init rises
        compared++;
        if (bus.sd_init !== 1'b1 || bus.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL init_start: got sd_init=%b busy=%b, want 1 1", bus.sd_init, bus.busy);
        end
        repeat (99) tick();
        compared++;
        if (bus.sd_init !== 1'b1 || bus.sd_release !== 1'b0) begin
            mismatched++;
            $display("FAIL init_hold: got sd_init=%b sd_release=%b, want 1 0", bus.sd_init, bus.sd_release);
        end
        bus.init_ok = 1'b1;  // seen at the 100th edge after sd_init rose
        tick();
        compared++;
        if (bus.sd_init !== 1'b0 || bus.sd_release !== 1'b1) begin
            mismatched++;
            $display("FAIL init_ok_resp: got sd_init=%b sd_release=%b, want 0 1", bus.sd_init, bus.sd_release);
        end
        rel_cnt = 0;
        while (bus.sd_release && rel_cnt < 20) begin
            rel_cnt++;
            tick();
        end
        compared++;
        if (rel_cnt !== 8) begin
            mismatched++;
            $display("FAIL init_release_len: got %0d cycles, want 8", rel_cnt);
        end
        compared++;
        if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
            mismatched++;
            $display("FAIL init_idle: got busy=%b gnt=%b, want 0 00", bus.busy, bus.gnt);
        end
    endtask

    task automatic test_init_fail();
        rst_f = 1'b1;
        tick();
        rst_f = 1'b0;
        tick();  // INIT_WAIT entry
        repeat (50) tick();
        compared++;
        if (bus_f.init_fail !== 1'b0) begin
            mismatched++;
            $display("FAIL init_fail_early: got init_fail=%b at cycle 50, want 0", bus_f.init_fail);
        end
        tick();
        compared++;
        if (bus_f.init_fail !== 1'b1 || bus_f.sd_init !== 1'b0 || bus_f.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL init_fail_set: got init_fail=%b sd_init=%b busy=%b, want 1 0 1",
                     bus_f.init_fail, bus_f.sd_init, bus_f.busy);
        end
        bus_f.req = 2'b01;
        repeat (6) tick();
        compared++;
        if (bus_f.gnt !== 2'b00 || bus_f.init_fail !== 1'b1 || bus_f.sd_ren !== 1'b0) begin
            mismatched++;
            $display("FAIL init_fail_no_gnt: got gnt=%b init_fail=%b sd_ren=%b, want 00 1 0",
                     bus_f.gnt, bus_f.init_fail, bus_f.sd_ren);
        end
        bus_f.req = 2'b00;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        bus.addr0 = 32'h0000_000A;
        bus.addr1 = 32'h0000_000B;
        bus.req   = 2'b11;
        for (int k = 0; k < 4; k++) begin
            e.gnt  = model_pick(2'b11) ? 2'b10 : 2'b01;
            e.addr = e.gnt[1] ? bus.addr1 : bus.addr0;
            sb.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!bus.sd_ren && n < 30) begin
                n++;
                tick();
            end
            e = sb.pop_front();
            compared++;
            if (!bus.sd_ren) begin
                mismatched++;
                $display("FAIL b2b_ren_timeout[%0d]: sd_ren=%b after 30 cycles, want 1", k, bus.sd_ren);
            end else if (bus.gnt !== e.gnt || bus.sd_addr !== e.addr) begin
                mismatched++;
                $display("FAIL b2b_grant[%0d]: got gnt=%b sd_addr=%h, want %b %h",
                         k, bus.gnt, bus.sd_addr, e.gnt, e.addr);
            end
            bus.sd_rd_done = 1'b1;
            tick();
            bus.sd_rd_done = 1'b0;
            compared++;
            if (bus.done !== e.gnt || bus.err !== 2'b00 || bus.sd_ren !== 1'b0) begin
                mismatched++;
                $display("FAIL b2b_done[%0d]: got done=%b err=%b sd_ren=%b, want %b 00 0",
                         k, bus.done, bus.err, bus.sd_ren, e.gnt);
            end
        end
        bus.req = 2'b00;
        n = 0;
        while (bus.busy && n < 30) begin
            n++;
            tick();
        end
        compared++;
        if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
            mismatched++;
            $display("FAIL b2b_idle: got busy=%b gnt=%b, want 0 00", bus.busy, bus.gnt);
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   rel_cnt;
        bus.addr0 = 32'h0000_1234;
        bus.req   = 2'b01;
        e.gnt  = model_pick(2'b01) ? 2'b10 : 2'b01;
        e.addr = bus.addr0;
        sb.push_back(e);
        tick();
        compared++;
        if (bus.gnt !== e.gnt || bus.sd_ren !== 1'b0) begin
            mismatched++;
            $display("FAIL single_gnt: got gnt=%b sd_ren=%b, want %b 0", bus.gnt, bus.sd_ren, e.gnt);
        end
        tick();
        compared++;
        if (bus.sd_ren !== 1'b1 || bus.sd_addr !== e.addr) begin
            mismatched++;
            $display("FAIL single_ren: got sd_ren=%b sd_addr=%h, want 1 %h", bus.sd_ren, bus.sd_addr, e.addr);
        end
        bus.addr0 = 32'hFFFF_0000;  // change after grant must not matter
        repeat (3) tick();
        compared++;
        if (bus.sd_ren !== 1'b1 || bus.sd_addr !== e.addr) begin
            mismatched++;
            $display("FAIL single_hold: got sd_ren=%b sd_addr=%h, want 1 %h", bus.sd_ren, bus.sd_addr, e.addr);
        end
        e = sb.pop_front();
        bus.sd_rd_done = 1'b1;
        tick();
        bus.sd_rd_done = 1'b0;
        bus.req = 2'b00;
        compared++;
        if (bus.done !== e.gnt || bus.sd_ren !== 1'b0 || bus.sd_release !== 1'b1) begin
            mismatched++;
            $display("FAIL single_done: got done=%b sd_ren=%b sd_release=%b, want %b 0 1",
                     bus.done, bus.sd_ren, bus.sd_release, e.gnt);
        end
        tick();
        compared++;
        if (bus.done !== 2'b00 || bus.gnt !== e.gnt) begin
            mismatched++;
            $display("FAIL single_pulse: got done=%b gnt=%b, want 00 %b", bus.done, bus.gnt, e.gnt);
        end
        rel_cnt = 1;
        while (bus.sd_release && rel_cnt < 20) begin
            rel_cnt++;
            tick();
        end
        compared++;
        if (rel_cnt !== 8 || bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL single_release: got %0d cycles gnt=%b busy=%b, want 8 00 0",
                     rel_cnt, bus.gnt, bus.busy);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n;
        bus.addr1 = 32'h0000_0C0C;
        bus.req   = 2'b10;
        e.gnt  = model_pick(2'b10) ? 2'b10 : 2'b01;
        e.addr = bus.addr1;
        sb.push_back(e);
        n = 0;
        while (!bus.sd_ren && n < 10) begin
            n++;
            tick();
        end
        e = sb.pop_front();
        compared++;
        if (bus.sd_ren !== 1'b1 || bus.gnt !== e.gnt || bus.sd_addr !== e.addr) begin
            mismatched++;
            $display("FAIL to_issue: got sd_ren=%b gnt=%b sd_addr=%h, want 1 %b %h",
                     bus.sd_ren, bus.gnt, bus.sd_addr, e.gnt, e.addr);
        end
        // Timer loaded with 20 when sd_ren rises; it reaches 0 twenty edges
        // later and the expiry is acted on at the following edge.
        repeat (20) tick();
        compared++;
        if (bus.err !== 2'b00 || bus.sd_ren !== 1'b1) begin
            mismatched++;
            $display("FAIL to_early: got err=%b sd_ren=%b, want 00 1", bus.err, bus.sd_ren);
        end
        tick();
        compared++;
        if (bus.err !== e.gnt || bus.done !== 2'b00 || bus.sd_ren !== 1'b0 || bus.sd_release !== 1'b1) begin
            mismatched++;
            $display("FAIL to_err: got err=%b done=%b sd_ren=%b sd_release=%b, want %b 00 0 1",
                     bus.err, bus.done, bus.sd_ren, bus.sd_release, e.gnt);
        end
        bus.req = 2'b00;
        n = 0;
        while (bus.busy && n < 30) begin
            n++;
            tick();
        end
        compared++;
        if (bus.busy !== 1'b0 || bus.gnt !== 2'b00 || bus.err !== 2'b00) begin
            mismatched++;
            $display("FAIL to_idle: got busy=%b gnt=%b err=%b, want 0 00 00", bus.busy, bus.gnt, bus.err);
        end
    endtask

    task automatic test_rst_mid();
        int n;
        bus.addr0 = 32'h0000_0055;
        bus.req   = 2'b01;
        n = 0;
        while (!bus.sd_ren && n < 10) begin
            n++;
            tick();
        end
        tick();
        compared++;
        if (bus.sd_ren !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid_setup: got sd_ren=%b, want 1", bus.sd_ren);
        end
        #1 rst = 1'b1;
        #1;
        compared++;
        if (bus.sd_ren !== 1'b0 || bus.gnt !== 2'b00 || bus.sd_release !== 1'b0 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_async: got sd_ren=%b gnt=%b sd_release=%b busy=%b, want 0 00 0 0",
                     bus.sd_ren, bus.gnt, bus.sd_release, bus.busy);
        end
        #1 rst = 1'b0;
        rr_m = 1'b1;
        bus.req = 2'b00;
        tick();
        compared++;
        if (bus.sd_init !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid_reinit: got sd_init=%b, want 1", bus.sd_init);
        end
        n = 0;
        while (bus.busy && n < 30) begin
            n++;
            tick();
        end
        // A stray completion pulse in IDLE must be ignored.
        bus.sd_rd_done = 1'b1;
        tick();
        bus.sd_rd_done = 1'b0;
        compared++;
        if (bus.busy !== 1'b0 || bus.done !== 2'b00 || bus.gnt !== 2'b00) begin
            mismatched++;
            $display("FAIL rst_mid_stray: got busy=%b done=%b gnt=%b, want 0 00 00", bus.busy, bus.done, bus.gnt);
        end
    endtask

    initial begin
        rst            = 1'b1;
        rst_f          = 1'b1;
        bus.req        = 2'b00;
        bus.addr0      = '0;
        bus.addr1      = '0;
        bus.init_ok    = 1'b0;
        bus.sd_rd_done = 1'b0;
        bus_f.req        = 2'b00;
        bus_f.addr0      = '0;
        bus_f.addr1      = '0;
        bus_f.init_ok    = 1'b0;
        bus_f.sd_rd_done = 1'b0;
        rr_m = 1'b1;

        test_reset();
        test_init();
        test_back_to_back();
        test_single();
        test_timeout();
        test_rst_mid();
        test_init_fail();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
